data_memory_lsu: RTL and testbench

- Parametrised successor of the single-cycle 32-bit data memory.
- Adds configurable depth and read latency, a valid/ready request port with one-shot response, RV32I byte/half/word loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) with sign/zero extension, and a fault flag for misaligned, out-of-range or illegal accesses.
- Sits between the core's ALU/decode stage and writeback.
- Only one request is outstanding at a time.

---
 rtl/data_memory_lsu.sv | 153 +++++++++++++++
 tb/tb_data_memory_lsu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu.sv
// Byte-lane data memory with a valid/ready load/store port, RV32I sub-word access
// and a configurable response latency. One request is outstanding at a time.

module data_memory_lsu_lane #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);
  logic [7:0] mem [2**ADDR_WIDTH];

  // Read-before-write: a store's own response never needs the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wdata;
    if (rd_en) rdata <= mem[idx];
  end
endmodule

module data_memory_lsu #(
  parameter int ADDR_WIDTH   = 6,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       fault;
  } req_t;

  state_t          state, state_n;
  logic [1:0]      cnt, cnt_n;
  req_t            req_q;
  logic            accept, fault;
  logic [3:0]      be;
  logic [3:0][7:0] lane_wdata, held;
  logic [31:0]     load_data, rdata_q;
  logic            fault_q;
  logic [7:0]      sel_b;
  logic [15:0]     sel_h;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    fault = 1'b0;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])         fault = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) fault = 1'b1;
    if (|req_addr[31:ADDR_WIDTH+2])                       fault = 1'b1;
    if (req_we && req_funct3 > 3'b010)                    fault = 1'b1;
    if (!req_we && (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)) fault = 1'b1;
  end

  // Store data is replicated across lanes; byte enables pick the live ones.
  always_comb begin
    be         = 4'b1111;
    lane_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be         = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    data_memory_lsu_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk   (clk),
      .rd_en (accept),
      .wr_en (accept && req_we && !fault && be[i]),
      .idx   (req_addr[ADDR_WIDTH+1:2]),
      .wdata (lane_wdata[i]),
      .rdata (held[i])
    );
  end

  always_comb begin
    sel_b     = held[req_q.off];
    sel_h     = req_q.off[1] ? {held[3], held[2]} : {held[1], held[0]};
    load_data = '0;
    if (!req_q.we && !req_q.fault) begin
      case (req_q.funct3)
        3'b000:  load_data = {{24{sel_b[7]}}, sel_b};
        3'b001:  load_data = {{16{sel_h[15]}}, sel_h};
        3'b010:  load_data = held;
        3'b100:  load_data = {24'd0, sel_b};
        3'b101:  load_data = {16'd0, sel_h};
        default: load_data = '0;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (accept) begin
        cnt_n   = 2'd0;
        state_n = (READ_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 2'(READ_LATENCY - 2)) state_n = RESP;
        else                             cnt_n   = cnt + 2'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      req_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) req_q <= '{we: req_we, funct3: req_funct3, off: req_addr[1:0], fault: fault};
      if (state == RESP) begin
        rdata_q <= load_data;
        fault_q <= req_q.fault;
      end
    end
  end

  // Live values during RESP, last response held otherwise.
  assign rsp_rdata = (state == RESP) ? load_data   : rdata_q;
  assign rsp_fault = (state == RESP) ? req_q.fault : fault_q;
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: one instance at latency 1, one at latency 3.

module tb_data_memory_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v1 = 1'b0, v3 = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rdy1, rdy3, rv1, rv3, f1, f3;
  logic [31:0] rd1, rd3;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  data_memory_lsu #(.ADDR_WIDTH(6), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_fault(f1));

  data_memory_lsu #(.ADDR_WIDTH(6), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(f3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance, checking latency and response.
  task automatic xact(input bit s3, input logic we, input logic [2:0] fn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_f, input string tag);
    int   lat;
    logic rv;
    @(negedge clk);
    chk({tag, "_rdy_pre"}, 32'(s3 ? rdy3 : rdy1), 32'd1);
    req_we = we; req_funct3 = fn; req_addr = addr; req_wdata = wdata;
    if (s3) v3 = 1'b1; else v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0; v3 = 1'b0;
    lat = 0; rv = 1'b0;
    while (!rv && lat < 10) begin
      @(negedge clk);
      lat++;
      rv = s3 ? rv3 : rv1;
      if (!rv) chk({tag, "_rdy_busy"}, 32'(s3 ? rdy3 : rdy1), 32'd0);
    end
    chk({tag, "_lat"}, 32'(lat), s3 ? 32'd3 : 32'd1);
    chk({tag, "_rdy_resp"}, 32'(s3 ? rdy3 : rdy1), 32'd0);
    chk({tag, "_rdata"}, s3 ? rd3 : rd1, exp_rd);
    chk({tag, "_fault"}, 32'(s3 ? f3 : f1), 32'(exp_f));
    @(negedge clk);
    chk({tag, "_rv_post"}, 32'(s3 ? rv3 : rv1), 32'd0);
    chk({tag, "_rdy_post"}, 32'(s3 ? rdy3 : rdy1), 32'd1);
  endtask

  initial begin
    logic [7:0]  rv_pat;
    logic [31:0] rd_a, rd_b;
    logic        any_rv;
    int          acc, rsp, consec;
    logic        prev;

    repeat (2) @(negedge clk);
    chk("rst_rdy1", 32'(rdy1), 32'd1);
    chk("rst_rv1", 32'(rv1), 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_f1", 32'(f1), 32'd0);
    chk("rst_rdy3", 32'(rdy3), 32'd1);
    chk("rst_rv3", 32'(rv3), 32'd0);
    rst = 1'b0;

    // latency 1: word store/load, then sub-word access
    xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, "sw10");
    xact(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, "lw10");
    xact(0, 1, 3'b000, 32'h11, 32'h000000A5, 32'h0,        0, "sb11");
    xact(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADA5EF, 0, "lw10b");
    xact(0, 0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFA5, 0, "lb11");
    xact(0, 0, 3'b100, 32'h11, 32'h0,        32'h000000A5, 0, "lbu11");
    xact(0, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, "lh12");
    xact(0, 0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 0, "lhu12");
    xact(0, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, "lb13");

    // faults: misaligned, out of range, illegal funct3
    xact(0, 0, 3'b010, 32'h12,  32'h0,    32'h0, 1, "f_lw12");
    xact(0, 1, 3'b001, 32'h13,  32'hFFFF, 32'h0, 1, "f_sh13");
    xact(0, 0, 3'b000, 32'h100, 32'h0,    32'h0, 1, "f_lb100");
    xact(0, 0, 3'b011, 32'h10,  32'h0,    32'h0, 1, "f_ld011");
    xact(0, 1, 3'b100, 32'h10,  32'h0,    32'h0, 1, "f_st100");
    xact(0, 1, 3'b010, 32'h110, 32'h0,    32'h0, 1, "f_sw110");
    xact(0, 0, 3'b010, 32'h10,  32'h0,    32'hDEADA5EF, 0, "lw10_nowr");

    // back-to-back with valid held for 10 cycles
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; v1 = 1'b1;
    acc = 0; rsp = 0; consec = 0; prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rdy1) acc++;
      @(negedge clk);
      if (rv1) rsp++;
      if (rv1 && prev) consec++;
      prev = rv1;
    end
    v1 = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd5);
    chk("b2b_rsp", 32'(rsp), 32'd5);
    chk("b2b_consec", 32'(consec), 32'd0);

    // latency 3, with a second request held through WAIT
    xact(1, 1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 0, "l3_sw10");
    xact(1, 1, 3'b001, 32'h16, 32'h00000102, 32'h0, 0, "l3_sh16");
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; v3 = 1'b1;
    @(posedge clk);
    #1 req_funct3 = 3'b001; req_addr = 32'h16;
    rv_pat = '0; rd_a = '0; rd_b = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rv_pat[8-i] = rv3;
      if (i == 3) rd_a = rd3;
      if (i == 7) rd_b = rd3;
      if (i == 4) begin
        @(posedge clk);
        #1 v3 = 1'b0;
      end
    end
    chk("l3_rv_pattern", 32'(rv_pat), 32'h22);
    chk("l3_first_rdata", rd_a, 32'hCAFEF00D);
    chk("l3_second_rdata", rd_b, 32'h00000102);

    // reset during WAIT drops the pending load
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; v3 = 1'b1;
    @(posedge clk);
    #1 v3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_rdy", 32'(rdy3), 32'd1);
    chk("rstmid_rv", 32'(rv3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    any_rv = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any_rv |= rv3;
    end
    chk("rstmid_no_rsp", 32'(any_rv), 32'd0);

    // store accepted just before reset stays written
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678; v3 = 1'b1;
    @(posedge clk);
    #1 v3 = 1'b0; rst = 1'b1;
    #1;
    chk("rstst_rdy", 32'(rdy3), 32'd1);
    chk("rstst_rv", 32'(rv3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xact(1, 0, 3'b010, 32'h20, 32'h0, 32'h12345678, 0, "l3_lw20");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
